// File: rtl/rr_input_arbiter.sv
// rtl/rr_input_arbiter.sv - packet-granular round-robin merge of three input streams
//
// Purpose: forwards whole packets from three slave streams onto one master
// stream. Each packet goes through unbuffered. The grant moves only at
// packet boundaries. Each port also has a count of forwarded packets.
//
// Ports:
//   axi_aclk, axi_resetn              clock, synchronous active-low reset
//   s_axis_*_0 .. s_axis_*_2          slave streams (tdata/tstrb/tuser/tvalid/tlast, tready out)
//   m_axis_*                          merged master stream (tready in)
//   rst_cntrs                         synchronous clear of the packet counters
//   pkt_fwd_cntr_0 .. pkt_fwd_cntr_2  packets forwarded per port
module rr_input_arbiter #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_CNTR_WIDTH         = 32
) (
    input  logic                                 axi_aclk,
    input  logic                                 axi_resetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata_0,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb_0,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser_0,
    input  logic                                 s_axis_tvalid_0,
    input  logic                                 s_axis_tlast_0,
    output logic                                 s_axis_tready_0,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata_1,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb_1,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser_1,
    input  logic                                 s_axis_tvalid_1,
    input  logic                                 s_axis_tlast_1,
    output logic                                 s_axis_tready_1,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata_2,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb_2,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser_2,
    input  logic                                 s_axis_tvalid_2,
    input  logic                                 s_axis_tlast_2,
    output logic                                 s_axis_tready_2,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,

    input  logic                                 rst_cntrs,
    output logic [C_CNTR_WIDTH-1:0]              pkt_fwd_cntr_0,
    output logic [C_CNTR_WIDTH-1:0]              pkt_fwd_cntr_1,
    output logic [C_CNTR_WIDTH-1:0]              pkt_fwd_cntr_2
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                  state;
    logic [1:0]              cur_port;
    logic [1:0]              last_port;
    logic [C_CNTR_WIDTH-1:0] cntr [3];

    logic [2:0] in_valid;
    logic [2:0] in_last;
    logic       sel_valid;
    logic       sel_last;
    logic       sending;
    logic       pkt_end;
    logic [1:0] cand_1;
    logic [1:0] cand_2;
    logic [1:0] pick_port;
    logic       pick_valid;

    assign in_valid = {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
    assign in_last  = {s_axis_tlast_2,  s_axis_tlast_1,  s_axis_tlast_0};

    // Port index plus offset, modulo 3; both operands are at most 2.
    function automatic logic [1:0] add_mod3(input logic [1:0] p, input logic [1:0] k);
        logic [2:0] sum;
        sum = {1'b0, p} + {1'b0, k};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    // Search starts just after the last served port, so the port served last
    // gets the lowest priority.
    assign cand_1 = add_mod3(last_port, 2'd1);
    assign cand_2 = add_mod3(last_port, 2'd2);

    always_comb begin
        pick_port  = last_port;
        pick_valid = |in_valid;
        if (in_valid[cand_1]) begin
            pick_port = cand_1;
        end else if (in_valid[cand_2]) begin
            pick_port = cand_2;
        end
    end

    // Datapath mux. No data is buffered; the master side is the granted
    // source itself.
    always_comb begin
        m_axis_tdata = s_axis_tdata_0;
        m_axis_tstrb = s_axis_tstrb_0;
        m_axis_tuser = s_axis_tuser_0;
        case (cur_port)
            2'd1: begin
                m_axis_tdata = s_axis_tdata_1;
                m_axis_tstrb = s_axis_tstrb_1;
                m_axis_tuser = s_axis_tuser_1;
            end
            2'd2: begin
                m_axis_tdata = s_axis_tdata_2;
                m_axis_tstrb = s_axis_tstrb_2;
                m_axis_tuser = s_axis_tuser_2;
            end
            default: ;
        endcase
    end

    assign sel_valid = in_valid[cur_port];
    assign sel_last  = in_last[cur_port];

    // Handshakes are gated by axi_resetn so nothing is offered while reset is
    // held, even before the first reset edge returns the FSM to IDLE.
    assign sending = axi_resetn && (state == SEND);

    assign m_axis_tvalid   = sending && sel_valid;
    assign m_axis_tlast    = sel_last;
    assign s_axis_tready_0 = sending && (cur_port == 2'd0) && m_axis_tready;
    assign s_axis_tready_1 = sending && (cur_port == 2'd1) && m_axis_tready;
    assign s_axis_tready_2 = sending && (cur_port == 2'd2) && m_axis_tready;

    assign pkt_end = m_axis_tvalid && m_axis_tready && sel_last;

    always_ff @(posedge axi_aclk) begin
        if (!axi_resetn) begin
            state     <= IDLE;
            cur_port  <= 2'd0;
            last_port <= 2'd2;
            for (int i = 0; i < 3; i++) begin
                cntr[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        cur_port <= pick_port;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (pkt_end) begin
                        last_port <= cur_port;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            for (int i = 0; i < 3; i++) begin
                if (rst_cntrs) begin
                    cntr[i] <= '0;
                end else if (pkt_end && (cur_port == 2'(i))) begin
                    cntr[i] <= cntr[i] + 1'b1;
                end
            end
        end
    end

    assign pkt_fwd_cntr_0 = cntr[0];
    assign pkt_fwd_cntr_1 = cntr[1];
    assign pkt_fwd_cntr_2 = cntr[2];

endmodule

// File: tb/tb_rr_input_arbiter.sv
// tb/tb_rr_input_arbiter.sv - directed self-checking bench for rr_input_arbiter
module tb_rr_input_arbiter;

    localparam int DW = 32;
    localparam int UW = 16;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic resetn;
    logic [DW-1:0]   s_tdata  [3];
    logic [DW/8-1:0] s_tstrb  [3];
    logic [UW-1:0]   s_tuser  [3];
    logic            s_tvalid [3];
    logic            s_tlast  [3];
    logic            s_tready [3];
    logic [DW-1:0]   m_tdata;
    logic [DW/8-1:0] m_tstrb;
    logic [UW-1:0]   m_tuser;
    logic            m_tvalid;
    logic            m_tlast;
    logic            m_tready;
    logic            rst_cntrs;
    logic [CW-1:0]   cnt0, cnt1, cnt2;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    rr_input_arbiter #(
        .C_M_AXIS_DATA_WIDTH(DW), .C_S_AXIS_DATA_WIDTH(DW),
        .C_M_AXIS_TUSER_WIDTH(UW), .C_S_AXIS_TUSER_WIDTH(UW),
        .C_CNTR_WIDTH(CW)
    ) dut (
        .axi_aclk(clk), .axi_resetn(resetn),
        .s_axis_tdata_0(s_tdata[0]), .s_axis_tstrb_0(s_tstrb[0]), .s_axis_tuser_0(s_tuser[0]),
        .s_axis_tvalid_0(s_tvalid[0]), .s_axis_tlast_0(s_tlast[0]), .s_axis_tready_0(s_tready[0]),
        .s_axis_tdata_1(s_tdata[1]), .s_axis_tstrb_1(s_tstrb[1]), .s_axis_tuser_1(s_tuser[1]),
        .s_axis_tvalid_1(s_tvalid[1]), .s_axis_tlast_1(s_tlast[1]), .s_axis_tready_1(s_tready[1]),
        .s_axis_tdata_2(s_tdata[2]), .s_axis_tstrb_2(s_tstrb[2]), .s_axis_tuser_2(s_tuser[2]),
        .s_axis_tvalid_2(s_tvalid[2]), .s_axis_tlast_2(s_tlast[2]), .s_axis_tready_2(s_tready[2]),
        .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .rst_cntrs(rst_cntrs),
        .pkt_fwd_cntr_0(cnt0), .pkt_fwd_cntr_1(cnt1), .pkt_fwd_cntr_2(cnt2)
    );

    // Accepted beats, sampled mid-cycle when inputs and outputs are settled.
    always @(negedge clk) begin
        if (m_tvalid && m_tready) hs_cnt <= hs_cnt + 1;
    end

    function automatic logic [DW-1:0] dat(input int p, input int i);
        return 32'hA000_0000 | 32'(p << 8) | 32'(i);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_beat(input int p, input int i, input logic last);
        s_tvalid[p] = 1'b1;
        s_tdata[p]  = dat(p, i);
        s_tstrb[p]  = 4'(i + 1);
        s_tuser[p]  = 16'(p * 16 + i);
        s_tlast[p]  = last;
    endtask

    task automatic clr(input int p);
        s_tvalid[p] = 1'b0;
        s_tlast[p]  = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, ".tvalid"}, 64'(m_tvalid), 64'd0);
        for (int q = 0; q < 3; q++) check($sformatf("%s.tready%0d", tag, q), 64'(s_tready[q]), 64'd0);
    endtask

    task automatic chk_beat(input string tag, input int p, input int i, input logic last);
        check({tag, ".tvalid"}, 64'(m_tvalid), 64'd1);
        check({tag, ".tdata"}, 64'(m_tdata), 64'(dat(p, i)));
        check({tag, ".tstrb"}, 64'(m_tstrb), 64'(i + 1));
        check({tag, ".tuser"}, 64'(m_tuser), 64'(p * 16 + i));
        check({tag, ".tlast"}, 64'(m_tlast), 64'(last));
        for (int q = 0; q < 3; q++)
            check($sformatf("%s.tready%0d", tag, q), 64'(s_tready[q]), (q == p) ? 64'(m_tready) : 64'd0);
    endtask

    task automatic chk_cnt(input string tag, input int e0, input int e1, input int e2);
        check({tag, ".cnt0"}, 64'(cnt0), 64'(e0));
        check({tag, ".cnt1"}, 64'(cnt1), 64'(e1));
        check({tag, ".cnt2"}, 64'(cnt2), 64'(e2));
    endtask

    // Entered just after the granting edge with beat 0 already presented.
    // Optionally raises a one-beat packet on port rp while beat ra is shown.
    task automatic run_pkt(input string tag, input int p, input int n, input int rp, input int ra);
        for (int i = 0; i < n; i++) begin
            if (i > 0) set_beat(p, i, (i == n - 1));
            if (i == ra) set_beat(rp, 0, 1'b1);
            #1;
            chk_beat($sformatf("%s.b%0d", tag, i), p, i, (i == n - 1));
            tick();
        end
        clr(p);
        #1;
        chk_idle({tag, ".idle"});
    endtask

    initial begin
        resetn = 1'b0; m_tready = 1'b1; rst_cntrs = 1'b0;
        for (int q = 0; q < 3; q++) begin
            clr(q);
            s_tdata[q] = '0; s_tstrb[q] = '0; s_tuser[q] = '0;
        end
        set_beat(1, 0, 1'b0);
        tick();
        tick();
        #1;
        chk_idle("rst");
        chk_cnt("rst", 0, 0, 0);
        clr(1);

        // All three ports request together: served 0, 1, 2.
        resetn = 1'b1;
        set_beat(0, 0, 1'b0); set_beat(1, 0, 1'b0); set_beat(2, 0, 1'b0);
        #1;
        chk_idle("a.first");
        tick(); run_pkt("a.p0", 0, 2, 3, 99);
        tick(); run_pkt("a.p1", 1, 2, 3, 99);
        tick(); run_pkt("a.p2", 2, 2, 3, 99);
        chk_cnt("a", 1, 1, 1);

        // Port 1 four beats; port 0 raises tvalid on its second beat.
        set_beat(1, 0, 1'b0);
        tick(); run_pkt("b.p1", 1, 4, 0, 1);
        tick(); run_pkt("b.p0", 0, 1, 3, 99);
        chk_cnt("b", 2, 2, 1);

        // Backpressure toggling during a three-beat packet from port 2.
        hs_cnt = 0;
        set_beat(2, 0, 1'b0);
        tick();
        m_tready = 1'b1; #1; chk_beat("c.0", 2, 0, 1'b0); tick();
        set_beat(2, 1, 1'b0); m_tready = 1'b0; #1; chk_beat("c.1s", 2, 1, 1'b0); tick();
        m_tready = 1'b1; #1; chk_beat("c.1", 2, 1, 1'b0); tick();
        set_beat(2, 2, 1'b1); m_tready = 1'b0; #1; chk_beat("c.2s", 2, 2, 1'b1); tick();
        m_tready = 1'b1; #1; chk_beat("c.2", 2, 2, 1'b1); tick();
        clr(2); #1;
        chk_idle("c.idle");
        check("c.beats", 64'(hs_cnt), 64'd3);
        chk_cnt("c", 2, 2, 2);

        // Clear counters, then port 2 alone sends three one-beat packets.
        rst_cntrs = 1'b1;
        tick();
        rst_cntrs = 1'b0; #1;
        chk_cnt("d.clr", 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            set_beat(2, 0, 1'b1);
            tick();
            run_pkt($sformatf("d.k%0d", k), 2, 1, 3, 99);
        end
        chk_cnt("d", 0, 0, 3);

        // Counter clear coincident with a tlast handshake.
        set_beat(0, 0, 1'b1); set_beat(1, 0, 1'b1);
        tick();
        rst_cntrs = 1'b1; #1;
        chk_beat("e.p0", 0, 0, 1'b1);
        tick();
        rst_cntrs = 1'b0; clr(0); #1;
        chk_idle("e.idle");
        chk_cnt("e.clr", 0, 0, 0);
        tick(); #1;
        chk_beat("e.p1", 1, 0, 1'b1);
        tick();
        clr(1); #1;
        chk_idle("e.idle2");
        chk_cnt("e", 0, 1, 0);

        // Reset in the middle of a four-beat packet from port 1.
        set_beat(1, 0, 1'b0);
        tick(); #1; chk_beat("f.0", 1, 0, 1'b0);
        tick(); set_beat(1, 1, 1'b0); #1; chk_beat("f.1", 1, 1, 1'b0);
        tick(); set_beat(1, 2, 1'b0); resetn = 1'b0; #1;
        chk_idle("f.inrst");
        tick(); #1;
        chk_idle("f.after");
        chk_cnt("f", 0, 0, 0);
        resetn = 1'b1;
        set_beat(0, 0, 1'b1); #1;
        chk_idle("f.rel");
        tick(); #1;
        chk_beat("f.p0", 0, 0, 1'b1);
        tick();
        clr(0); clr(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
